// File: rtl/ast_feed_ctrl_if.sv
// ast_feed_ctrl_if: bundles the control/status signals between the feed
// sequencer and its environment (lane FIFO bank plus run control).
//
//   start, stall, abort  run control into the sequencer
//   lane_empty[LANES]    empty flags from the lane FIFOs
//   load[LANES]          parallel_load strobes to the lane FIFOs
//   pop[LANES]           pop strobes to the lane FIFOs
//   valid_out[LANES]     lane data_out holds valid data this cycle
//   busy, done, err      run status
//
// slave  : the sequencer side (ast_feed_ctrl)
// master : the side that drives run control and owns the FIFOs
interface ast_feed_ctrl_if #(
    parameter int LANES = 8
);
    logic             start;
    logic             stall;
    logic             abort;
    logic [LANES-1:0] lane_empty;
    logic [LANES-1:0] load;
    logic [LANES-1:0] pop;
    logic [LANES-1:0] valid_out;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, stall, abort, lane_empty,
        input  load, pop, valid_out, busy, done, err
    );

    modport slave (
        input  start, stall, abort, lane_empty,
        output load, pop, valid_out, busy, done, err
    );
endinterface

// File: rtl/ast_feed_ctrl.sv
// ast_feed_ctrl: sequencer for a bank of LANES parallel-loadable lane FIFOs
// feeding a systolic array. A run loads every lane in one cycle, then pops
// DEPTH entries from each lane with a diagonal skew (lane i starts i cycles
// after lane 0) so operands reach the array wavefront-aligned.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  ast_feed_ctrl_if.slave (start/stall/abort/lane_empty in,
//        load/pop/valid_out/busy/done/err out); the interface LANES
//        parameter must match this module's LANES.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; no strobes
// S_LOAD   | one cycle, parallel_load every lane
// S_STREAM | skewed pops, cnt = 0 .. DEPTH+LANES-2, frozen while stalled
// S_DRAIN  | one cycle, no pops, last pop's valid_out shows
// S_DONE   | one cycle, done pulse; start ignored here
module ast_feed_ctrl #(
    parameter int LANES = 8,
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    ast_feed_ctrl_if.slave bus
);
    localparam int            CW        = $clog2(DEPTH + LANES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEPTH + LANES - 2);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [LANES-1:0] r_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [LANES-1:0] w_pop;
    logic [LANES-1:0] w_load;

    // Lane i is active for cnt in [i, i+DEPTH). The cnt >= i test comes
    // first so the subtraction never wraps.
    always_comb begin
        w_pop = '0;
        if ((r_state == S_STREAM) && !bus.stall) begin
            for (int i = 0; i < LANES; i++) begin
                if ((r_cnt >= CW'(i)) && ((r_cnt - CW'(i)) < CNT_DEPTH)) begin
                    w_pop[i] = 1'b1;
                end
            end
        end
    end

    assign w_load = (r_state == S_LOAD) ? {LANES{1'b1}} : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // Matches the one-cycle data_out latency of the lane FIFOs;
            // a pop issued in an aborting cycle is still reported.
            r_valid <= w_pop;
            r_done  <= 1'b0;
            if (|(w_pop & bus.lane_empty)) begin
                r_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_cnt <= '0;
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (!bus.stall) begin
                        if (r_cnt == CNT_LAST) begin
                            r_state <= S_DRAIN;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    r_busy <= 1'b0;
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load      = w_load;
    assign bus.pop       = w_pop;
    assign bus.valid_out = r_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_ast_feed_ctrl.sv
module tb_ast_feed_ctrl;
    localparam int LANES = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ast_feed_ctrl_if #(.LANES(LANES)) bus ();

    ast_feed_ctrl #(
        .LANES(LANES),
        .DEPTH(DEPTH)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stall;
        logic       abort;
        logic [3:0] le;
        logic [3:0] load;
        logic [3:0] pop;
        logic [3:0] vld;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   pop_cnt[LANES];

    function automatic void add(input logic st, input logic sl, input logic ab,
                                input logic [3:0] le, input logic [3:0] ld,
                                input logic [3:0] pp, input logic [3:0] vl,
                                input logic bz, input logic dn, input logic er);
        vec_t v;
        v.start = st; v.stall = sl; v.abort = ab; v.le = le;
        v.load = ld; v.pop = pp; v.vld = vl;
        v.busy = bz; v.done = dn; v.err = er;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        else
            n_pass++;
    endtask

    // Drive one row just after a rising edge, queue its expectation,
    // compare on the falling edge, then advance to the next cycle.
    task automatic apply(input int idx);
        vec_t v;
        vec_t e;
        v = vecs[idx];
        bus.start      = v.start;
        bus.stall      = v.stall;
        bus.abort      = v.abort;
        bus.lane_empty = v.le;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("load",  idx, 32'(bus.load),      32'(e.load));
        chk("pop",   idx, 32'(bus.pop),       32'(e.pop));
        chk("valid", idx, 32'(bus.valid_out), 32'(e.vld));
        chk("busy",  idx, 32'(bus.busy),      32'(e.busy));
        chk("done",  idx, 32'(bus.done),      32'(e.done));
        chk("err",   idx, 32'(bus.err),       32'(e.err));
        for (int i = 0; i < LANES; i++)
            if (bus.pop[i]) pop_cnt[i]++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int k = lo; k < hi; k++) apply(k);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < LANES; i++) pop_cnt[i] = 0;
    endtask

    task automatic check_counts(input string nm);
        for (int i = 0; i < LANES; i++) chk(nm, i, 32'(pop_cnt[i]), 32'(DEPTH));
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_load"},  0, 32'(bus.load),      32'd0);
        chk({nm, "_pop"},   0, 32'(bus.pop),       32'd0);
        chk({nm, "_valid"}, 0, 32'(bus.valid_out), 32'd0);
        chk({nm, "_busy"},  0, 32'(bus.busy),      32'd0);
        chk({nm, "_done"},  0, 32'(bus.done),      32'd0);
        chk({nm, "_err"},   0, 32'(bus.err),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_nom, s_stall, s_abort, s_filt, s_post;

        bus.start      = 1'b0;
        bus.stall      = 1'b0;
        bus.abort      = 1'b0;
        bus.lane_empty = '0;

        // Nominal run: start sampled at the first edge.
        //   st sl ab le    ld    pop   vld   bz dn er
        add(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h0, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h3, 4'h1, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h7, 4'h3, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'hF, 4'h7, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'hE, 4'hF, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'hC, 4'hE, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h8, 4'hC, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h8, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        s_nom = vecs.size();

        // Stall ignored in LOAD; stall during cycles 4-5 freezes the skew.
        add(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        add(0, 1, 0, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h0, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h3, 4'h1, 1, 0, 0);
        add(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h3, 1, 0, 0);
        add(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h7, 4'h0, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'hF, 4'h7, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'hE, 4'hF, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'hC, 4'hE, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h8, 4'hC, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h8, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        s_stall = vecs.size();

        // Abort in STREAM (final pop still issued and reported), restart,
        // abort in LOAD, then abort together with stall.
        add(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h0, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h3, 4'h1, 1, 0, 0);
        add(0, 0, 1, 4'h0, 4'h0, 4'h7, 4'h3, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h7, 0, 0, 0);
        add(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        add(0, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        add(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h0, 1, 0, 0);
        add(0, 1, 1, 4'h0, 4'h0, 4'h0, 4'h1, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        s_abort = vecs.size();

        // Error: lane 2 empty; only the cycle where pop[2]=1 sets err.
        // Also a stall on the final count delays DRAIN by one cycle.
        add(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        add(0, 0, 0, 4'h4, 4'hF, 4'h0, 4'h0, 1, 0, 0);
        add(0, 0, 0, 4'h4, 4'h0, 4'h1, 4'h0, 1, 0, 0);
        add(0, 0, 0, 4'h4, 4'h0, 4'h3, 4'h1, 1, 0, 0);
        add(0, 0, 0, 4'h4, 4'h0, 4'h7, 4'h3, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'hF, 4'h7, 1, 0, 1);
        add(0, 0, 0, 4'h0, 4'h0, 4'hE, 4'hF, 1, 0, 1);
        add(0, 0, 0, 4'h0, 4'h0, 4'hC, 4'hE, 1, 0, 1);
        add(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'hC, 1, 0, 1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h8, 4'h0, 1, 0, 1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h8, 1, 0, 1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1);

        // start held high: ignored while busy and in DONE, next run
        // loads one IDLE cycle after DONE. err stays sticky.
        add(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1);
        add(1, 0, 0, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 1);
        add(1, 0, 0, 4'h0, 4'h0, 4'h1, 4'h0, 1, 0, 1);
        add(1, 0, 0, 4'h0, 4'h0, 4'h3, 4'h1, 1, 0, 1);
        add(1, 0, 0, 4'h0, 4'h0, 4'h7, 4'h3, 1, 0, 1);
        add(1, 0, 0, 4'h0, 4'h0, 4'hF, 4'h7, 1, 0, 1);
        add(1, 0, 0, 4'h0, 4'h0, 4'hE, 4'hF, 1, 0, 1);
        add(1, 0, 0, 4'h0, 4'h0, 4'hC, 4'hE, 1, 0, 1);
        add(1, 0, 0, 4'h0, 4'h0, 4'h8, 4'hC, 1, 0, 1);
        add(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h8, 1, 0, 1);
        add(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 1);
        add(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1);
        add(0, 0, 0, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h0, 1, 0, 1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h3, 4'h1, 1, 0, 1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h7, 4'h3, 1, 0, 1);
        s_filt = vecs.size();

        // After async reset: quiet IDLE, then a clean start.
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        add(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0, 0);
        add(0, 0, 1, 4'h0, 4'h0, 4'h1, 4'h0, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h1, 0, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        s_post = vecs.size();

        #12;
        check_all_zero("reset");
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        clear_counts();
        run_rows(0, s_nom);
        check_counts("nom_pops");

        clear_counts();
        run_rows(s_nom, s_stall);
        check_counts("stall_pops");

        run_rows(s_stall, s_abort);
        run_rows(s_abort, s_filt);

        // Mid-STREAM (cnt=3, all lanes popping): reset between edges.
        chk("pre_rst_pop",  0, 32'(bus.pop),  32'hF);
        chk("pre_rst_busy", 0, 32'(bus.busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        run_rows(s_filt, s_post);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ast_feed_ctrl.md
Name: ast_feed_ctrl

Overview:
- Sequencer for a bank of LANES parallel-loadable FIFOs (ast_ldfifo instances) that feed a systolic array.
- On start, it parallel-loads every lane in one cycle. It then issues diagonally skewed pops: lane i starts popping i cycles after lane 0, so operands reach the array wavefront-aligned.
- It produces per-lane valid strobes aligned to the FIFOs' registered data_out, plus busy, done and error status.

Parameters:
- LANES, 8, number of FIFO lanes controlled (>=1).
- DEPTH, 8, entries per lane FIFO; pops issued per lane per run (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  begin a run; sampled only in IDLE.
- stall  input  1  freeze skew sequencing; no pops while high.
- abort  input  1  synchronous cancel of a run in progress.
- lane_empty  input  LANES  empty flags from the lane FIFOs.
- load  output  LANES  parallel_load strobes, one per lane.
- pop  output  LANES  pop strobes, one per lane.
- valid_out  output  LANES  lane data_out holds valid data this cycle.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at run completion.
- err  output  1  sticky: a pop was issued to an empty lane.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0; load, pop, valid_out, busy, done, err all 0 immediately. Reset mid-run discards the run and produces no done.
- States: IDLE, LOAD, STREAM, DRAIN, DONE. Transitions occur on rising clk only.
- IDLE: start=1 -> LOAD. All strobes are 0.
- LOAD: lasts exactly 1 cycle. load={LANES{1}}, pop=0. Next state STREAM with cnt=0. stall is ignored in LOAD.
- STREAM: cnt counts 0..DEPTH+LANES-2, width $clog2(DEPTH+LANES).
  - pop[i] = !stall && (cnt >= i) && (cnt-i < DEPTH).
  - Compare unsigned, with no underflow: use cnt>=i before subtracting.
  - cnt increments only when stall=0.
  - When cnt==DEPTH+LANES-2 and stall=0, go to DRAIN.
- DRAIN: 1 cycle, no pops. Lets the last pop's valid_out appear. Next state DONE.
- DONE: 1 cycle, done=1. Next state IDLE. A start in DONE is ignored; start must be presented in IDLE.
- busy=1 in LOAD, STREAM and DRAIN; 0 in IDLE and DONE.
- load and pop are combinational decodes of state, cnt and stall. No register lies between them and the FIFOs.
- valid_out is registered: valid_out[i] <= pop[i]. This matches the ast_ldfifo data_out one-cycle latency.
- Each lane receives exactly DEPTH pops per completed run. Total STREAM cycles are DEPTH+LANES-1 plus the number of stalled cycles.
- err: set when pop[i] && lane_empty[i] for any i. Cleared only by reset. The controller does not gate pop on lane_empty.
- abort=1 in LOAD, STREAM or DRAIN:
  - next state IDLE, cnt=0, no done.
  - pop is still driven combinationally that cycle unless stall=1; abort does not mask it.
  - valid_out captures that final pop normally.
- abort has no effect in IDLE or DONE.
- Simultaneous stall and abort: abort wins for the state transition; stall still masks pop.
- LANES=1: pure DEPTH-cycle pop burst, with no skew.

Test Plan:
- Nominal, LANES=4, DEPTH=4. start pulsed in IDLE at edge 0 -> then:
  - load=4'hF in cycle 1 only.
  - pop[0] cycles 2-5; pop[3] cycles 5-8.
  - valid_out[3] cycles 6-9.
  - busy cycles 1-9; done=1 in cycle 10 only.
  - Exactly 4 pops per lane.
- Stall, same config. stall=1 during cycles 4-5 -> pop=0 during the stall and cnt frozen. Sequence resumes intact, each lane still gets 4 pops, done moves to cycle 12.
- Abort. abort=1 in cycle 4 -> IDLE in cycle 5, busy=0, pop=0 from cycle 5, done never pulses. A start in cycle 6 begins a fresh run with load in cycle 7.
- Error. lane_empty[2]=1 forced while pop[2]=1 -> err=1 from the next cycle and stays 1 through following runs until rst=0.
- Async reset. rst driven low mid-STREAM, between clock edges -> all outputs 0 immediately without a clock edge. After release, the block sits in IDLE with no spurious load or pop.
- Start filtering. start held high continuously -> back-to-back runs, each separated by DONE and IDLE cycles. start pulses during busy are ignored.
